timer_scheduler_rr: RTL and testbench

- Shares one N-bit up-counter among R requesters, each asking for an exclusive timed window of a requested length.
- Grants are round-robin. The block runs the shared counter for the granted window, then pulses a per-requester done.
- Sits between user control logic (FSMs, debounced buttons) and the shared timing resource on the lab board designs.

---
 rtl/timer_scheduler_rr_pkg.sv | 26 ++
 rtl/timer_scheduler_rr_if.sv | 22 ++
 rtl/timer_scheduler_rr_contador_en_nbits.sv | 25 ++
 rtl/timer_scheduler_rr.sv | 94 +++++++++
 tb/tb_timer_scheduler_rr.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/timer_scheduler_rr_pkg.sv
// Shared types and the round-robin index search for the timer scheduler.
// Pure declarations: no latency, no flow control.
package timer_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam int MAX_R = 8;

  // First set bit of req at or above ptr, wrapping modulo r; 0 when req is empty.
  function automatic int rr_pick(input logic [MAX_R-1:0] req, input int ptr, input int r);
    int sel;
    int idx;
    logic found;
    sel = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_R; i++) begin
      idx = (ptr + i) % r;
      if (i < r && !found && req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/timer_scheduler_rr_if.sv
// Requester-side bundle of the timer scheduler: request/duration in, grant/done/count out.
// Level handshake: req held until done or abort; no other backpressure.
interface timer_scheduler_rr_if
  import timer_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
);
  localparam int OW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]         req;
  logic [R-1:0][N-1:0]  dur;
  logic [R-1:0]         grant;
  logic [R-1:0]         done;
  logic                 busy;
  logic [N-1:0]         count;
  logic [OW-1:0]        owner;

  modport master (output req, dur, input grant, done, busy, count, owner);
  modport slave  (input req, dur, output grant, done, busy, count, owner);

endinterface

// File: rtl/timer_scheduler_rr_contador_en_nbits.sv
// N-bit up-counter with synchronous clear (priority) and enable.
// One-cycle update latency; no flow control.
module contador_en_nbits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [N-1:0] count
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/timer_scheduler_rr.sv
// Round-robin owner of one shared counter: grant next cycle after req, done dur_l cycles later.
// Requesters hold req until done; dropping req[owner] aborts the window with no done.
module timer_scheduler_rr
  import timer_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic clk,
  input  logic reset,
  timer_scheduler_rr_if.slave bus
);

  localparam int OW = $clog2(R);
  localparam logic [OW-1:0] LAST_IDX = OW'(R - 1);

  sched_state_t    r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [N-1:0]    r_dur_l;

  logic [MAX_R-1:0] w_req8;
  logic [OW-1:0]    w_pick;
  logic [OW-1:0]    w_next_ptr;
  logic [N-1:0]     w_count;
  logic             w_last;
  logic             w_clear;
  logic             w_en;

  always_comb begin
    w_req8 = '0;
    w_req8[R-1:0] = bus.req;
  end

  assign w_pick     = OW'(rr_pick(w_req8, int'(r_ptr), R));
  assign w_next_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
  assign w_last     = (w_count == r_dur_l - 1'b1);
  assign w_en       = (r_state == RUN);
  assign w_clear    = (r_state != RUN);

  contador_en_nbits #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_en),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_dur_l <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_owner <= w_pick;
            r_dur_l <= bus.dur[w_pick];
            r_state <= (bus.dur[w_pick] == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // An abort wins over a coinciding final cycle: the owner gave up the window.
          if (!bus.req[r_owner]) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
          end else if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= w_next_ptr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, never req.
  always_comb begin
    bus.grant = '0;
    bus.done  = '0;
    if (r_state == RUN)  bus.grant[r_owner] = 1'b1;
    if (r_state == DONE) bus.done[r_owner]  = 1'b1;
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.count = (r_state == RUN) ? w_count : '0;
  assign bus.owner = r_owner;

endmodule

// File: tb/tb_timer_scheduler_rr.sv
// Directed bench for timer_scheduler_rr with hand-computed cycle-by-cycle expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_scheduler_rr;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  timer_scheduler_rr_if #(.N(8), .R(4)) bus ();

  timer_scheduler_rr #(.N(8), .R(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered on the first RUN cycle (or the DONE cycle when d==0); leaves on the following IDLE cycle.
  task automatic window(input string tag, input int idx, input int d);
    for (int i = 0; i < d; i++) begin
      chk({tag, ".grant"}, 32'(bus.grant), 1 << idx);
      chk({tag, ".count"}, 32'(bus.count), i);
      chk({tag, ".owner"}, 32'(bus.owner), idx);
      step();
    end
    chk({tag, ".done"},       32'(bus.done),  1 << idx);
    chk({tag, ".done_grant"}, 32'(bus.grant), 0);
    chk({tag, ".done_count"}, 32'(bus.count), 0);
    chk({tag, ".done_busy"},  32'(bus.busy),  1);
    step();
    chk({tag, ".idle_busy"},  32'(bus.busy),  0);
    chk({tag, ".idle_done"},  32'(bus.done),  0);
  endtask

  int ord [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ord      = '{0, 1, 3, 0, 1, 3};
    reset    = 1'b1;
    bus.req  = '0;
    bus.dur  = '0;
    step();
    step();
    chk("rst.grant", 32'(bus.grant), 0);
    chk("rst.done",  32'(bus.done),  0);
    chk("rst.busy",  32'(bus.busy),  0);
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.owner", 32'(bus.owner), 0);
    reset = 1'b0;
    step();

    // Single requester, 5-cycle window.
    bus.req    = 4'b0001;
    bus.dur[0] = 8'd5;
    step();
    window("single", 0, 5);
    bus.req = '0;

    // Round-robin from a fresh pointer.
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bus.req = 4'b1011;
    bus.dur = {8'd2, 8'd2, 8'd2, 8'd2};
    step();
    for (int k = 0; k < 6; k++) begin
      window("rr", ord[k], 2);
      if (k == 5) bus.req = '0;
      step();
    end

    // Zero duration: straight to DONE.
    bus.req    = 4'b0100;
    bus.dur[2] = 8'd0;
    step();
    window("zero", 2, 0);
    bus.req = '0;

    // Abort requester 1 after three grant cycles; requester 2 waits.
    bus.req    = 4'b0110;
    bus.dur[1] = 8'd10;
    bus.dur[2] = 8'd3;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("abort.grant", 32'(bus.grant), 32'b0010);
      chk("abort.count", 32'(bus.count), i);
      if (i == 2) bus.req = 4'b0100;
      step();
    end
    chk("abort.idle_grant", 32'(bus.grant), 0);
    chk("abort.idle_done",  32'(bus.done),  0);
    chk("abort.idle_busy",  32'(bus.busy),  0);
    chk("abort.idle_count", 32'(bus.count), 0);
    chk("abort.idle_owner", 32'(bus.owner), 1);
    step();
    window("abort_next", 2, 3);
    bus.req = '0;

    // Reset in the middle of requester 3's window.
    bus.req    = 4'b1000;
    bus.dur[3] = 8'd20;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("midrst.count", 32'(bus.count), 7);
    chk("midrst.grant", 32'(bus.grant), 32'b1000);
    reset      = 1'b1;
    bus.req    = 4'b1001;
    bus.dur[0] = 8'd1;
    step();
    chk("midrst.grant0", 32'(bus.grant), 0);
    chk("midrst.done0",  32'(bus.done),  0);
    chk("midrst.busy0",  32'(bus.busy),  0);
    chk("midrst.count0", 32'(bus.count), 0);
    chk("midrst.owner0", 32'(bus.owner), 0);
    reset = 1'b0;
    step();
    window("post_rst", 0, 1);
    bus.req = '0;

    // Maximum duration: count runs 0..254 without wrapping.
    bus.req    = 4'b0001;
    bus.dur[0] = 8'd255;
    step();
    window("maxdur", 0, 255);
    bus.req = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
